// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared widths, state encodings and master ids for the memory bus arbiter
package mem_bus_arbiter_pkg;
   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
   localparam logic MST_LSU = 1'b0;
   localparam logic MST_IF = 1'b1;
endpackage

// File: rtl/arb_timeout_cnt.sv
// arb_timeout_cnt: loadable watchdog up-counter with clear, enable and expiry flag
module arb_timeout_cnt #(
   parameter int W = 8,
   parameter int LIM = 63
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         clr,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         en,
   output logic         exp
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (ld) cnt <= ld_val;
      else if (en) cnt <= cnt + 1'b1;
   assign exp = cnt == W'(LIM);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master single-outstanding arbiter with fetch starvation guard and response watchdog
module mem_bus_arbiter import mem_bus_arbiter_pkg::*; #(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          m0_req_vld_i,
   output logic          m0_req_rdy_o,
   input  logic [AW-1:0] m0_addr_i,
   input  logic          m0_we_i,
   input  logic [DW-1:0] m0_wdata_i,
   input  logic [DW/8-1:0] m0_wstrb_i,
   output logic          m0_rsp_vld_o,
   output logic          m0_rsp_err_o,
   output logic [DW-1:0] m0_rdata_o,
   input  logic          m1_req_vld_i,
   output logic          m1_req_rdy_o,
   input  logic [AW-1:0] m1_addr_i,
   output logic          m1_rsp_vld_o,
   output logic          m1_rsp_err_o,
   output logic [DW-1:0] m1_rdata_o,
   output logic          s_req_vld_o,
   input  logic          s_req_rdy_i,
   output logic [AW-1:0] s_addr_o,
   output logic          s_we_o,
   output logic [DW-1:0] s_wdata_o,
   output logic [DW/8-1:0] s_wstrb_o,
   input  logic          s_rsp_vld_i,
   input  logic [DW-1:0] s_rdata_i,
   output logic          m1_stall_o
);
   state_t state, state_nxt;
   logic owner, win, idle, wait_st, hs, rsp, to_exp;
   logic [3:0] starve_cnt;
   arb_timeout_cnt #(.W(8), .LIM(TIMEOUT - 1)) u_to (
      .clk(clk), .rstn(rstn), .clr(hs), .ld(1'b0), .ld_val('0),
      .en(wait_st & ~s_rsp_vld_i), .exp(to_exp)
   );
   // request side is gated by rstn so every output reads 0 while reset is held
   always_comb begin
      idle = rstn & (state == ST_IDLE);
      wait_st = state == ST_WAIT;
      win = (m1_req_vld_i & (starve_cnt >= 4'(STARVE_MAX))) ? MST_IF : (m0_req_vld_i ? MST_LSU : MST_IF);
      s_req_vld_o = idle & (m0_req_vld_i | m1_req_vld_i);
      hs = s_req_vld_o & s_req_rdy_i;
      m0_req_rdy_o = idle & s_req_rdy_i & m0_req_vld_i & (win == MST_LSU);
      m1_req_rdy_o = idle & s_req_rdy_i & m1_req_vld_i & (win == MST_IF);
      s_addr_o = !s_req_vld_o ? '0 : (win == MST_IF) ? m1_addr_i : m0_addr_i;
      s_we_o = s_req_vld_o & (win == MST_LSU) & m0_we_i;
      s_wdata_o = (s_req_vld_o & (win == MST_LSU)) ? m0_wdata_i : '0;
      s_wstrb_o = (s_req_vld_o & (win == MST_LSU)) ? m0_wstrb_i : '0;
      rsp = wait_st & (s_rsp_vld_i | to_exp);
      m0_rsp_vld_o = rsp & (owner == MST_LSU);
      m1_rsp_vld_o = rsp & (owner == MST_IF);
      m0_rsp_err_o = m0_rsp_vld_o & ~s_rsp_vld_i;
      m1_rsp_err_o = m1_rsp_vld_o & ~s_rsp_vld_i;
      m0_rdata_o = (m0_rsp_vld_o & s_rsp_vld_i) ? s_rdata_i : '0;
      m1_rdata_o = (m1_rsp_vld_o & s_rsp_vld_i) ? s_rdata_i : '0;
      m1_stall_o = rstn & m1_req_vld_i & ~(m1_req_rdy_o & s_req_rdy_i);
      state_nxt = hs ? ST_WAIT : rsp ? ST_IDLE : state;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= ST_IDLE;
         owner <= MST_LSU;
         starve_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (hs) owner <= win;
         if (!m1_req_vld_i) starve_cnt <= '0;
         else if (hs) starve_cnt <= (win == MST_IF) ? 4'd0 : (starve_cnt >= 4'(STARVE_MAX)) ? starve_cnt : starve_cnt + 4'd1;
      end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks of grant order, starvation guard, timeout and reset behaviour
module tb_mem_bus_arbiter;
   logic clk = 0, rstn = 0;
   logic m0_req_vld_i = 0, m0_req_rdy_o, m0_we_i = 0, m0_rsp_vld_o, m0_rsp_err_o;
   logic [31:0] m0_addr_i = 0, m0_wdata_i = 0, m0_rdata_o;
   logic [3:0] m0_wstrb_i = 0;
   logic m1_req_vld_i = 0, m1_req_rdy_o, m1_rsp_vld_o, m1_rsp_err_o, m1_stall_o;
   logic [31:0] m1_addr_i = 0, m1_rdata_o;
   logic s_req_vld_o, s_req_rdy_i = 0, s_we_o, s_rsp_vld_i = 0;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i = 0;
   logic [3:0] s_wstrb_o;
   int total = 0, bad = 0;

   mem_bus_arbiter dut (
      .clk(clk), .rstn(rstn),
      .m0_req_vld_i(m0_req_vld_i), .m0_req_rdy_o(m0_req_rdy_o), .m0_addr_i(m0_addr_i),
      .m0_we_i(m0_we_i), .m0_wdata_i(m0_wdata_i), .m0_wstrb_i(m0_wstrb_i),
      .m0_rsp_vld_o(m0_rsp_vld_o), .m0_rsp_err_o(m0_rsp_err_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_vld_i(m1_req_vld_i), .m1_req_rdy_o(m1_req_rdy_o), .m1_addr_i(m1_addr_i),
      .m1_rsp_vld_o(m1_rsp_vld_o), .m1_rsp_err_o(m1_rsp_err_o), .m1_rdata_o(m1_rdata_o),
      .s_req_vld_o(s_req_vld_o), .s_req_rdy_i(s_req_rdy_i), .s_addr_o(s_addr_o),
      .s_we_o(s_we_o), .s_wdata_o(s_wdata_o), .s_wstrb_o(s_wstrb_o),
      .s_rsp_vld_i(s_rsp_vld_i), .s_rdata_i(s_rdata_i), .m1_stall_o(m1_stall_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      tick(); tick();
      chk("rst_s_vld", s_req_vld_o, 0);
      chk("rst_m0_rdy", m0_req_rdy_o, 0);
      chk("rst_m1_rdy", m1_req_rdy_o, 0);
      chk("rst_m0_rsp", m0_rsp_vld_o, 0);
      chk("rst_m1_rsp", m1_rsp_vld_o, 0);
      chk("rst_stall", m1_stall_o, 0);
      rstn = 1;
      tick();
      // fetch-only read
      m1_req_vld_i = 1; m1_addr_i = 32'h0; s_req_rdy_i = 1;
      #1;
      chk("t1_s_vld", s_req_vld_o, 1);
      chk("t1_m1_rdy", m1_req_rdy_o, 1);
      chk("t1_m0_rdy", m0_req_rdy_o, 0);
      chk("t1_s_we", s_we_o, 0);
      chk("t1_stall", m1_stall_o, 0);
      tick();
      m1_req_vld_i = 0;
      #1;
      chk("t1_wait_rdy", m1_req_rdy_o, 0);
      chk("t1_wait_svld", s_req_vld_o, 0);
      chk("t1_no_early_rsp", m1_rsp_vld_o, 0);
      tick();
      s_rsp_vld_i = 1; s_rdata_i = 32'h00100093;
      #1;
      chk("t1_rsp_vld", m1_rsp_vld_o, 1);
      chk("t1_rdata", m1_rdata_o, 32'h00100093);
      chk("t1_err", m1_rsp_err_o, 0);
      chk("t1_m0_rsp", m0_rsp_vld_o, 0);
      chk("t1_m0_rdata", m0_rdata_o, 0);
      tick();
      s_rsp_vld_i = 0;
      #1;
      chk("t1_rsp_pulse", m1_rsp_vld_o, 0);
      // simultaneous LSU write and fetch
      m0_req_vld_i = 1; m0_we_i = 1; m0_addr_i = 32'h1000; m0_wdata_i = 32'hDEADBEEF; m0_wstrb_i = 4'hF;
      m1_req_vld_i = 1; m1_addr_i = 32'h4;
      #1;
      chk("t2_we", s_we_o, 1);
      chk("t2_addr", s_addr_o, 32'h1000);
      chk("t2_wdata", s_wdata_o, 32'hDEADBEEF);
      chk("t2_wstrb", s_wstrb_o, 4'hF);
      chk("t2_m0_rdy", m0_req_rdy_o, 1);
      chk("t2_m1_rdy", m1_req_rdy_o, 0);
      chk("t2_stall_a", m1_stall_o, 1);
      tick();
      m0_req_vld_i = 0; m0_we_i = 0;
      #1;
      chk("t2_stall_b", m1_stall_o, 1);
      tick();
      s_rsp_vld_i = 1; s_rdata_i = 32'h0;
      #1;
      chk("t2_m0_rsp", m0_rsp_vld_o, 1);
      chk("t2_m1_rsp", m1_rsp_vld_o, 0);
      chk("t2_stall_c", m1_stall_o, 1);
      tick();
      s_rsp_vld_i = 0;
      #1;
      chk("t2_m1_grant", m1_req_rdy_o, 1);
      chk("t2_m1_addr", s_addr_o, 32'h4);
      chk("t2_m1_we", s_we_o, 0);
      chk("t2_stall_d", m1_stall_o, 0);
      tick();
      m1_req_vld_i = 0; s_rsp_vld_i = 1; s_rdata_i = 32'h11;
      #1;
      chk("t2_m1_rsp", m1_rsp_vld_o, 1);
      chk("t2_m1_rdata", m1_rdata_o, 32'h11);
      tick();
      s_rsp_vld_i = 0;
      // continuous contention: m0 x4 then m1
      m0_req_vld_i = 1; m0_addr_i = 32'h2000; m1_req_vld_i = 1;
      for (int g = 0; g < 10; g++) begin
         #1;
         chk($sformatf("t3_grant%0d", g), m1_req_rdy_o, (g % 5) == 4);
         chk($sformatf("t3_m0rdy%0d", g), m0_req_rdy_o, (g % 5) != 4);
         tick();
         s_rsp_vld_i = 1;
         #1;
         chk($sformatf("t3_owner%0d", g), m1_rsp_vld_o, (g % 5) == 4);
         tick();
         s_rsp_vld_i = 0;
      end
      m0_req_vld_i = 0; m1_req_vld_i = 0;
      tick();
      // timeout
      m0_req_vld_i = 1; m0_addr_i = 32'h2000; s_rdata_i = 32'hBAD;
      tick();
      m0_req_vld_i = 0;
      for (int c = 1; c < 64; c++) begin
         #1;
         chk($sformatf("t4_quiet%0d", c), m0_rsp_vld_o, 0);
         tick();
      end
      #1;
      chk("t4_to_vld", m0_rsp_vld_o, 1);
      chk("t4_to_err", m0_rsp_err_o, 1);
      chk("t4_to_rdata", m0_rdata_o, 0);
      chk("t4_m1_rsp", m1_rsp_vld_o, 0);
      tick();
      #1;
      chk("t4_pulse", m0_rsp_vld_o, 0);
      repeat (4) tick();
      s_rsp_vld_i = 1;
      #1;
      chk("t4_late_m0", m0_rsp_vld_o, 0);
      chk("t4_late_m1", m1_rsp_vld_o, 0);
      tick();
      s_rsp_vld_i = 0;
      // reset during WAIT_RSP
      m1_req_vld_i = 1; m1_addr_i = 32'h8;
      tick();
      m1_req_vld_i = 0;
      tick();
      rstn = 0; m0_req_vld_i = 1; m0_addr_i = 32'h3000;
      for (int r = 0; r < 3; r++) begin
         #1;
         chk($sformatf("t5_svld%0d", r), s_req_vld_o, 0);
         chk($sformatf("t5_m0rdy%0d", r), m0_req_rdy_o, 0);
         chk($sformatf("t5_addr%0d", r), s_addr_o, 0);
         tick();
      end
      rstn = 1; m0_req_vld_i = 0; s_rsp_vld_i = 1;
      #1;
      chk("t5_drop_m1", m1_rsp_vld_o, 0);
      chk("t5_drop_m0", m0_rsp_vld_o, 0);
      tick();
      s_rsp_vld_i = 0; m0_req_vld_i = 1;
      #1;
      chk("t5_next_rdy", m0_req_rdy_o, 1);
      chk("t5_next_addr", s_addr_o, 32'h3000);
      tick();
      m0_req_vld_i = 0; s_rsp_vld_i = 1; s_rdata_i = 32'h55;
      #1;
      chk("t5_next_rsp", m0_rsp_vld_o, 1);
      chk("t5_next_rdata", m0_rdata_o, 32'h55);
      tick();
      s_rsp_vld_i = 0;
      // slave backpressure
      s_req_rdy_i = 0; m1_req_vld_i = 1; m1_addr_i = 32'h40;
      for (int b = 0; b < 3; b++) begin
         #1;
         chk($sformatf("t6_rdy%0d", b), m1_req_rdy_o, 0);
         chk($sformatf("t6_stall%0d", b), m1_stall_o, 1);
         chk($sformatf("t6_addr%0d", b), s_addr_o, 32'h40);
         tick();
      end
      s_req_rdy_i = 1;
      #1;
      chk("t6_accept", m1_req_rdy_o, 1);
      chk("t6_unstall", m1_stall_o, 0);
      tick();
      m1_req_vld_i = 0;
      #1;
      chk("t6_in_wait", s_req_vld_o, 0);
      s_rsp_vld_i = 1; s_rdata_i = 32'h77;
      #1;
      chk("t6_rsp", m1_rdata_o, 32'h77);
      tick();
      s_rsp_vld_i = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
